// File: rtl/sha_nonce_scheduler.sv
// Nonce-sweep sequencer for the multi-nonce SHA-256 engine: launches one engine
// run per batch, scans the per-lane h0 results against a target, stops on hit/exhaustion/abort.
module sha_nonce_scheduler #(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [31:0]       cfg_nonce_start,
  input  logic [15:0]       cfg_num_batches,
  input  logic [31:0]       cfg_target,
  output logic              eng_start,
  output logic [31:0]       eng_nonce_base,
  input  logic              eng_done,
  output logic [IDX_W-1:0]  res_idx,
  input  logic [31:0]       res_h0,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              aborted,
  output logic [31:0]       hit_nonce,
  output logic [31:0]       hit_h0,
  output logic [15:0]       batches_done
);

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned BATCH_W = 16;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_NONCES - 1);
  localparam logic [NONCE_W-1:0] BATCH_STEP = NONCE_W'(NUM_NONCES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SCAN,
    S_FINISH
  } state_t;

  state_t               state, state_d;
  logic [NONCE_W-1:0]   target_q, target_d;
  logic [BATCH_W-1:0]   num_batches_q, num_batches_d;
  logic                 abort_pending, abort_pending_d;

  logic                 eng_start_d;
  logic [NONCE_W-1:0]   eng_nonce_base_d;
  logic [IDX_W-1:0]     res_idx_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 hit_d;
  logic                 aborted_d;
  logic [NONCE_W-1:0]   hit_nonce_d;
  logic [NONCE_W-1:0]   hit_h0_d;
  logic [BATCH_W-1:0]   batches_done_d;

  logic                 abort_now;
  logic                 lane_hit;
  logic [BATCH_W-1:0]   batches_inc;

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      target_q       <= '0;
      num_batches_q  <= '0;
      abort_pending  <= 1'b0;
      eng_start      <= 1'b0;
      eng_nonce_base <= '0;
      res_idx        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      hit            <= 1'b0;
      aborted        <= 1'b0;
      hit_nonce      <= '0;
      hit_h0         <= '0;
      batches_done   <= '0;
    end else begin
      state          <= state_d;
      target_q       <= target_d;
      num_batches_q  <= num_batches_d;
      abort_pending  <= abort_pending_d;
      eng_start      <= eng_start_d;
      eng_nonce_base <= eng_nonce_base_d;
      res_idx        <= res_idx_d;
      busy           <= busy_d;
      done           <= done_d;
      hit            <= hit_d;
      aborted        <= aborted_d;
      hit_nonce      <= hit_nonce_d;
      hit_h0         <= hit_h0_d;
      batches_done   <= batches_done_d;
    end
  end

  assign abort_now   = abort_pending | cfg_abort;
  assign lane_hit    = (res_h0 < target_q);
  assign batches_inc = batches_done + BATCH_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d          = state;
    target_d         = target_q;
    num_batches_d    = num_batches_q;
    abort_pending_d  = abort_pending;
    eng_nonce_base_d = eng_nonce_base;
    res_idx_d        = res_idx;
    hit_d            = hit;
    aborted_d        = aborted;
    hit_nonce_d      = hit_nonce;
    hit_h0_d         = hit_h0;
    batches_done_d   = batches_done;

    unique case (state)
      S_IDLE: begin
        if (cfg_start) begin
          target_d         = cfg_target;
          num_batches_d    = cfg_num_batches;
          abort_pending_d  = 1'b0;
          eng_nonce_base_d = cfg_nonce_start;
          hit_d            = 1'b0;
          aborted_d        = 1'b0;
          hit_nonce_d      = '0;
          hit_h0_d         = '0;
          batches_done_d   = '0;
          state_d          = (cfg_num_batches == '0) ? S_FINISH : S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        if (cfg_abort) abort_pending_d = 1'b1;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (cfg_abort) abort_pending_d = 1'b1;
        if (eng_done) begin
          res_idx_d = '0;
          if (abort_now) begin
            aborted_d = 1'b1;
            state_d   = S_FINISH;
          end else begin
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        if (cfg_abort) abort_pending_d = 1'b1;
        if (lane_hit) begin
          // A hit outranks any abort raised in the same batch.
          hit_d       = 1'b1;
          hit_nonce_d = eng_nonce_base + NONCE_W'(res_idx);
          hit_h0_d    = res_h0;
          state_d     = S_FINISH;
        end else if (res_idx != LAST_IDX) begin
          res_idx_d = res_idx + IDX_W'(1);
        end else begin
          batches_done_d   = batches_inc;
          eng_nonce_base_d = eng_nonce_base + BATCH_STEP;
          if (batches_inc == num_batches_q) begin
            state_d = S_FINISH;
          end else if (abort_now) begin
            aborted_d = 1'b1;
            state_d   = S_FINISH;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end

      S_FINISH: begin
        // Zero-batch sweeps arrive with done low and linger one cycle to emit it.
        state_d = done ? S_IDLE : S_FINISH;
      end

      default: state_d = S_IDLE;
    endcase

    eng_start_d = (state_d == S_LAUNCH);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH) && (state != S_IDLE);
  end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench for sha_nonce_scheduler with a small behavioural engine model
// that returns a single programmable hit lane.
module tb_sha_nonce_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic        cfg_abort;
  logic [31:0] cfg_nonce_start;
  logic [15:0] cfg_num_batches;
  logic [31:0] cfg_target;
  logic        eng_start;
  logic [31:0] eng_nonce_base;
  logic        eng_done;
  logic [3:0]  res_idx;
  logic [31:0] res_h0;
  logic        busy;
  logic        done;
  logic        hit;
  logic        aborted;
  logic [31:0] hit_nonce;
  logic [31:0] hit_h0;
  logic [15:0] batches_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cyc = 0;

  // Engine model state.
  logic        model_done  = 1'b0;
  logic        inject_done = 1'b0;
  int          cnt_down    = 0;
  int          eng_lat     = 4;
  int          starts      = 0;
  int          ed_cyc      = 0;
  logic [31:0] bases [64];
  logic [31:0] base_lat    = 32'h0;
  logic        hit_en      = 1'b0;
  logic [31:0] hit_base    = 32'h0;
  logic [3:0]  hit_lane    = 4'h0;
  logic [31:0] hit_val     = 32'h0;

  sha_nonce_scheduler #(.NUM_NONCES(16), .IDX_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_start       (cfg_start),
    .cfg_abort       (cfg_abort),
    .cfg_nonce_start (cfg_nonce_start),
    .cfg_num_batches (cfg_num_batches),
    .cfg_target      (cfg_target),
    .eng_start       (eng_start),
    .eng_nonce_base  (eng_nonce_base),
    .eng_done        (eng_done),
    .res_idx         (res_idx),
    .res_h0          (res_h0),
    .busy            (busy),
    .done            (done),
    .hit             (hit),
    .aborted         (aborted),
    .hit_nonce       (hit_nonce),
    .hit_h0          (hit_h0),
    .batches_done    (batches_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign eng_done = model_done | inject_done;
  assign res_h0   = (hit_en && base_lat == hit_base && res_idx == hit_lane) ? hit_val : 32'hFFFF_FFFF;

  // Engine: latch base on eng_start, pulse done eng_lat cycles later.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (cnt_down > 0) begin
      cnt_down = cnt_down - 1;
      if (cnt_down == 0) begin
        model_done = 1'b1;
        ed_cyc     = cyc;
      end
    end
    if (eng_start === 1'b1) begin
      if (starts < 64) bases[starts] = eng_nonce_base;
      starts   = starts + 1;
      base_lat = eng_nonce_base;
      cnt_down = eng_lat;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start_sweep(input logic [31:0] ns, input logic [15:0] nb, input logic [31:0] tgt);
    cfg_nonce_start = ns;
    cfg_num_batches = nb;
    cfg_target      = tgt;
    cfg_start       = 1'b1;
    tick();
    cfg_start       = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i;
    i = 0;
    while (done !== 1'b1 && i < bound) begin
      tick();
      i++;
    end
    check(tag, 32'(done), 32'd1);
    done_cyc = cyc;
  endtask

  task automatic wait_eng_done(input string tag, input int bound);
    int i;
    i = 0;
    while (eng_done !== 1'b1 && i < bound) begin
      tick();
      i++;
    end
    check(tag, 32'(eng_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0;
    int act;
    reset           = 1'b1;
    cfg_start       = 1'b0;
    cfg_abort       = 1'b0;
    cfg_nonce_start = 32'h0;
    cfg_num_batches = 16'h0;
    cfg_target      = 32'h0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_busy",      32'(busy),         32'd0);
    check("rst_eng_start", 32'(eng_start),    32'd0);
    check("rst_base",      eng_nonce_base,    32'h0);
    check("rst_idx",       32'(res_idx),      32'd0);
    check("rst_flags",     32'({done, hit, aborted}), 32'd0);
    check("rst_hit_nonce", hit_nonce,         32'h0);
    check("rst_bd",        32'(batches_done), 32'd0);

    // Basic two-batch sweep with no possible hit
    eng_lat = 4;
    s0 = starts;
    start_sweep(32'h0000_1000, 16'd2, 32'h0);
    check("basic_busy",      32'(busy),      32'd1);
    check("basic_eng_start", 32'(eng_start), 32'd1);
    wait_done("basic_done", 300);
    check("basic_latency",   32'(done_cyc - ed_cyc), 32'd17);
    check("basic_hit",       32'(hit),          32'd0);
    check("basic_bd",        32'(batches_done), 32'd2);
    check("basic_starts",    32'(starts - s0),  32'd2);
    check("basic_base0",     bases[s0],         32'h0000_1000);
    check("basic_base1",     bases[s0 + 1],     32'h0000_1010);
    tick();
    check("basic_idle",      32'({busy, done}), 32'd0);

    // Hit on base 0x1010 lane 5
    hit_en   = 1'b1;
    hit_base = 32'h0000_1010;
    hit_lane = 4'd5;
    hit_val  = 32'h0000_0800;
    s0 = starts;
    start_sweep(32'h0000_1000, 16'd4, 32'h0000_1000);
    wait_done("hit_done", 300);
    check("hit_latency", 32'(done_cyc - ed_cyc), 32'd7);
    check("hit_flag",    32'(hit),          32'd1);
    check("hit_aborted", 32'(aborted),      32'd0);
    check("hit_nonce",   hit_nonce,         32'h0000_1015);
    check("hit_h0",      hit_h0,            32'h0000_0800);
    check("hit_bd",      32'(batches_done), 32'd1);
    check("hit_starts",  32'(starts - s0),  32'd2);
    hit_en = 1'b0;
    tick();

    // Abort while the engine is running
    eng_lat = 100;
    s0 = starts;
    start_sweep(32'h0000_2000, 16'd8, 32'h0);
    repeat (3) tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    wait_done("abort_done", 300);
    check("abort_latency", 32'(done_cyc - ed_cyc), 32'd1);
    check("abort_flag",    32'(aborted),      32'd1);
    check("abort_hit",     32'(hit),          32'd0);
    check("abort_bd",      32'(batches_done), 32'd0);
    check("abort_idx",     32'(res_idx),      32'd0);
    check("abort_starts",  32'(starts - s0),  32'd1);
    eng_lat = 4;
    tick();

    // Nonce base wraps across 2^32
    s0 = starts;
    start_sweep(32'hFFFF_FFF8, 16'd2, 32'h0);
    wait_done("wrap_done", 300);
    check("wrap_base0",  bases[s0],         32'hFFFF_FFF8);
    check("wrap_base1",  bases[s0 + 1],     32'h0000_0008);
    check("wrap_final",  eng_nonce_base,    32'h0000_0018);
    check("wrap_bd",     32'(batches_done), 32'd2);
    tick();

    // Lane-0 hit together with abort: hit wins
    hit_en   = 1'b1;
    hit_base = 32'h0000_3000;
    hit_lane = 4'd0;
    hit_val  = 32'h0000_0010;
    s0 = starts;
    start_sweep(32'h0000_3000, 16'd3, 32'h0000_1000);
    wait_eng_done("hba_eng_done", 100);
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("hba_done",    32'(done),    32'd1);
    check("hba_hit",     32'(hit),     32'd1);
    check("hba_aborted", 32'(aborted), 32'd0);
    check("hba_nonce",   hit_nonce,    32'h0000_3000);
    check("hba_h0",      hit_h0,       32'h0000_0010);
    check("hba_starts",  32'(starts - s0), 32'd1);
    hit_en = 1'b0;
    tick();

    // Zero-batch sweep
    s0 = starts;
    start_sweep(32'h0000_7000, 16'd0, 32'h0);
    check("zero_t1", 32'({busy, eng_start, done}), 32'b100);
    tick();
    check("zero_done", 32'(done), 32'd1);
    tick();
    check("zero_idle", 32'({busy, done}), 32'd0);
    check("zero_starts", 32'(starts - s0), 32'd0);

    // Start while busy is ignored
    s0 = starts;
    start_sweep(32'h0000_4000, 16'd1, 32'h0);
    tick();
    start_sweep(32'h0000_9000, 16'd5, 32'h0);
    wait_done("busy_done", 300);
    check("busy_starts", 32'(starts - s0),  32'd1);
    check("busy_bd",     32'(batches_done), 32'd1);
    check("busy_base",   eng_nonce_base,    32'h0000_4010);
    tick();

    // Synchronous reset during SCAN, then a stray eng_done
    s0 = starts;
    start_sweep(32'h0000_5000, 16'd2, 32'h0);
    wait_eng_done("rscan_eng_done", 100);
    repeat (3) tick();
    check("rscan_in_scan", 32'(res_idx), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rscan_busy", 32'(busy),      32'd0);
    check("rscan_base", eng_nonce_base, 32'h0);
    check("rscan_idx",  32'(res_idx),   32'd0);
    inject_done = 1'b1;
    tick();
    inject_done = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1 || eng_start === 1'b1 || done === 1'b1) act++;
    end
    check("rscan_quiet",  32'(act),          32'd0);
    check("rscan_starts", 32'(starts - s0),  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha_nonce_scheduler.md
# sha_nonce_scheduler

Sequences the multi-nonce SHA-256 hash engine across a nonce sweep. The block issues one engine run per batch of `NUM_NONCES` consecutive nonces and scans the engine's per-nonce results against a 32-bit difficulty target. It stops on the first hit, on exhausting the requested batch count, or on abort. It sits between the host/config layer and the bitcoin hash engine, and owns the engine's start, nonce-base and result-select inputs.

## Interface
- `NUM_NONCES`, 16: nonces per engine run; power of two, ≥2.
- `IDX_W`, 4: log2(`NUM_NONCES`).
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high; sampled on `clk`.
- `cfg_start` in 1: one-cycle pulse that begins a sweep; ignored unless in IDLE.
- `cfg_abort` in 1: level or pulse; requests early termination.
- `cfg_nonce_start` in 32: first nonce of the sweep; latched on accepted start.
- `cfg_num_batches` in 16: number of engine runs; latched on accepted start.
- `cfg_target` in 32: a result is a hit when `res_h0` < target (unsigned); latched on accepted start.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_nonce_base` out 32: nonce of engine lane 0; held stable from `eng_start` until `eng_done`.
- `eng_done` in 1: one-cycle pulse; engine results are valid from this cycle until the next `eng_start`.
- `res_idx` out IDX_W: lane select into the engine result array.
- `res_h0` in 32: combinational engine output for lane `res_idx`, valid in the same cycle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `hit` out 1: sweep found a nonce; held until next accepted start.
- `aborted` out 1: sweep ended by abort; held until next accepted start.
- `hit_nonce` out 32: winning nonce, equal to base + lane.
- `hit_h0` out 32: winning `res_h0`.
- `batches_done` out 16: count of fully scanned batches.

## Operation
- States: IDLE, LAUNCH, WAIT, SCAN, FINISH. All outputs are registered.
- IDLE, on `cfg_start`:
  - Latch the config inputs.
  - Set `eng_nonce_base`=`cfg_nonce_start`.
  - Clear `hit`, `aborted`, `hit_nonce`, `hit_h0`, `batches_done`.
  - If `cfg_num_batches`==0, go to FINISH (no engine run). Otherwise go to LAUNCH.
- LAUNCH: assert `eng_start` for exactly this cycle, then go to WAIT.
- WAIT: hold until `eng_done`. On `eng_done`, clear `res_idx` to 0.
  - If an abort is pending, set `aborted` and go to FINISH.
  - Otherwise go to SCAN.
- SCAN: one lane per cycle, in order `res_idx`=0..NUM_NONCES-1.
  - Hit (`res_h0` < target): capture `hit_nonce`=`eng_nonce_base`+`res_idx` (mod 2^32) and `hit_h0`=`res_h0`, set `hit`, go to FINISH. `batches_done` is not incremented.
  - No hit, lane below last: increment `res_idx`.
  - No hit, last lane:
    - Increment `batches_done`.
    - `eng_nonce_base` += `NUM_NONCES`; this wraps mod 2^32.
    - If `batches_done`+1 == latched count, go to FINISH.
    - Else if an abort is pending, set `aborted` and go to FINISH.
    - Else go to LAUNCH.
- FINISH: pulse `done` for one cycle, then go to IDLE.
- Abort handling:
  - `cfg_abort` in LAUNCH or WAIT sets `abort_pending`. The engine cannot be cancelled, so the block always waits for `eng_done` before finishing.
  - `cfg_abort` in SCAN sets `abort_pending`. The current batch's scan completes, so a hit in this batch is still reported.
  - `abort_pending` clears on an accepted start.
- Simultaneous hit and abort: the hit wins; `hit`=1, `aborted`=0.
- `cfg_start` while busy is ignored. `cfg_abort` in IDLE is ignored.
- `eng_done` outside WAIT is ignored.
- Reset mid-sweep: the FSM returns to IDLE and all outputs go to reset values. The engine may still finish, and its `eng_done` is ignored.

## Timing
- Reset values: `eng_start`=0, `eng_nonce_base`=0, `res_idx`=0, `busy`=0, `done`=0, `hit`=0, `aborted`=0, `hit_nonce`=0, `hit_h0`=0, `batches_done`=0.
- `cfg_start` sampled at edge T: `busy` and the LAUNCH state at T+1, with `eng_start`=1 during the cycle after T.
- `eng_done` sampled at edge E: lane 0 is compared during cycle E+1. A no-hit batch finishes scanning at E+`NUM_NONCES`.
- Between batches: the next `eng_start` is asserted one cycle after the last scan cycle.
- Hit on lane k: `done` is high during cycle E+k+2. `hit`, `hit_nonce` and `hit_h0` are valid at or before the `done` pulse.
- Zero-batch sweep: `done` is high during cycle T+2.
- Per-batch overhead beyond engine latency: `NUM_NONCES`+2 cycles.

## Test plan
- Basic sweep: start=0x1000, batches=2, target=0. Expect 2 `eng_start` pulses with bases 0x1000 then 0x1010. Expect `done` with `hit`=0, `batches_done`=2.
- Hit: batches=4, target=0x00001000. The model returns `res_h0`=0x00000800 only for base 0x1010, lane 5. Expect `hit_nonce`=0x1015, `hit_h0`=0x00000800, `batches_done`=1, and exactly 2 `eng_start` pulses.
- Abort in WAIT: batches=8. Pulse `cfg_abort` 3 cycles after `eng_start`, and delay `eng_done` 100 cycles. Expect no SCAN, `done` one cycle after `eng_done`, `aborted`=1, `batches_done`=0.
- Wrap and hit-beats-abort: start=0xFFFFFFF8, batches=2. Second base must be 0x00000008. In a separate run, assert a lane-0 hit together with `cfg_abort` in the same cycle. Expect `hit`=1, `aborted`=0.
- Edge cases: batches=0 gives `done` at T+2 with no `eng_start`. `cfg_start` while busy is ignored. Synchronous `reset` during SCAN returns all outputs to zero next cycle, and a later `eng_done` causes no activity.
